// File: rtl/ula_pkg.sv
// rtl/ula_pkg.sv - opcode constants and FSM state encoding for ula_multiciclo
package ula_pkg;

    localparam logic [3:0] ULA_AND  = 4'b0000;
    localparam logic [3:0] ULA_OR   = 4'b0001;
    localparam logic [3:0] ULA_ADD  = 4'b0010;
    localparam logic [3:0] ULA_SUB  = 4'b0110;
    localparam logic [3:0] ULA_SLT  = 4'b0111;
    localparam logic [3:0] ULA_NOR  = 4'b1100;
    localparam logic [3:0] ULA_MUL  = 4'b1000;
    localparam logic [3:0] ULA_DIVU = 4'b1001;
    localparam logic [3:0] ULA_REMU = 4'b1010;

    typedef enum logic [0:0] {
        OCIOSO = 1'b0,
        CALC   = 1'b1
    } ula_estado_t;

endpackage

// File: rtl/ula_muldiv_seq.sv
// rtl/ula_muldiv_seq.sv - iterative shift-add multiplier and restoring divider
module ula_muldiv_seq
    import ula_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_INI = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_ULT = CW'(1);

    // Shared working registers:
    //   MUL: x = accumulator, y = multiplicand (shifts left), z = multiplier (shifts right)
    //   DIV: x = partial remainder, y = divisor, z = dividend turning into quotient
    logic [WIDTH-1:0] reg_x, reg_y, reg_z;
    logic [3:0]       op_r;
    logic             busy;
    logic [CW-1:0]    cnt;

    logic [WIDTH-1:0] mul_x;
    logic [WIDTH:0]   desloc, dif;
    logic [WIDTH-1:0] div_x, div_z;
    logic [WIDTH-1:0] prox_x, prox_y, prox_z;
    logic             is_mul;

    // One iteration of either algorithm, plus the value seen after the last one
    always_comb begin
        is_mul = (op_r == ULA_MUL);
        mul_x  = reg_x + (reg_z[0] ? reg_y : '0);
        desloc = {reg_x, reg_z[WIDTH-1]};
        dif    = desloc - {1'b0, reg_y};
        if (dif[WIDTH]) begin
            div_x = desloc[WIDTH-1:0];
            div_z = {reg_z[WIDTH-2:0], 1'b0};
        end else begin
            div_x = dif[WIDTH-1:0];
            div_z = {reg_z[WIDTH-2:0], 1'b1};
        end
        prox_x = is_mul ? mul_x : div_x;
        prox_y = is_mul ? {reg_y[WIDTH-2:0], 1'b0} : reg_y;
        prox_z = is_mul ? {1'b0, reg_z[WIDTH-1:1]} : div_z;
        if (is_mul)
            result = mul_x;
        else if (op_r == ULA_REMU)
            result = div_x;
        else
            result = div_z;
        done = busy && (cnt == CNT_ULT);
    end

    // Load operands on start, then run exactly WIDTH iterations
    always_ff @(posedge clock) begin
        if (reset) begin
            busy <= 1'b0;
            cnt  <= '0;
        end else if (start) begin
            busy  <= 1'b1;
            cnt   <= CNT_INI;
            op_r  <= op;
            reg_x <= '0;
            reg_y <= (op == ULA_MUL) ? a : b;
            reg_z <= (op == ULA_MUL) ? b : a;
        end else if (busy) begin
            reg_x <= prox_x;
            reg_y <= prox_y;
            reg_z <= prox_z;
            cnt   <= cnt - CNT_ULT;
            if (cnt == CNT_ULT)
                busy <= 1'b0;
        end
    end

endmodule

// File: rtl/ula_multiciclo.sv
// rtl/ula_multiciclo.sv - multi-cycle ALU top; ULA_MULDIV_EN enables MUL/DIVU/REMU
module ula_multiciclo
    import ula_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inicio,
    input  logic [3:0]       controladorULA,
    input  logic [WIDTH-1:0] dados1,
    input  logic [WIDTH-1:0] dados2,
    output logic [WIDTH-1:0] saida,
    output logic             zero,
    output logic             pronto,
    output logic             ocupado,
    output logic             erro
);

    ula_estado_t      estado, estado_prox;
    logic [WIDTH-1:0] res_ula, res_prox, seq_result;
    logic             err_ula, err_prox, vai_calc, inicia_seq, carrega, seq_done;

    // Single-cycle result and classification of the incoming opcode
    always_comb begin
        res_ula  = '0;
        err_ula  = 1'b0;
        vai_calc = 1'b0;
        case (controladorULA)
            ULA_AND: res_ula = dados1 & dados2;
            ULA_OR:  res_ula = dados1 | dados2;
            ULA_ADD: res_ula = dados1 + dados2;
            ULA_SUB: res_ula = dados1 - dados2;
            ULA_SLT: res_ula[0] = $signed(dados1) < $signed(dados2);
            ULA_NOR: res_ula = ~(dados1 | dados2);
`ifdef ULA_MULDIV_EN
            ULA_MUL: vai_calc = 1'b1;
            ULA_DIVU: begin
                if (dados2 == '0) begin
                    res_ula = '1;
                    err_ula = 1'b1;
                end else begin
                    vai_calc = 1'b1;
                end
            end
            ULA_REMU: begin
                if (dados2 == '0) begin
                    res_ula = dados1;
                    err_ula = 1'b1;
                end else begin
                    vai_calc = 1'b1;
                end
            end
`endif
            default: err_ula = 1'b1;
        endcase
    end

`ifdef ULA_MULDIV_EN
    ula_muldiv_seq #(.WIDTH(WIDTH)) u_seq (
        .clock  (clock),
        .reset  (reset),
        .start  (inicia_seq),
        .op     (controladorULA),
        .a      (dados1),
        .b      (dados2),
        .done   (seq_done),
        .result (seq_result)
    );
    assign ocupado = (estado == CALC);
`else
    assign seq_done   = 1'b0;
    assign seq_result = '0;
    assign ocupado    = 1'b0;
`endif

    // FSM state register
    always_ff @(posedge clock) begin
        if (reset)
            estado <= OCIOSO;
        else
            estado <= estado_prox;
    end

    // Next state, accept decision and which result gets registered
    always_comb begin
        estado_prox = estado;
        inicia_seq  = 1'b0;
        carrega     = 1'b0;
        res_prox    = res_ula;
        err_prox    = err_ula;
        case (estado)
            OCIOSO: begin
                if (inicio) begin
                    if (vai_calc) begin
                        inicia_seq  = 1'b1;
                        estado_prox = CALC;
                    end else begin
                        carrega = 1'b1;
                    end
                end
            end
            CALC: begin
                if (seq_done) begin
                    carrega     = 1'b1;
                    res_prox    = seq_result;
                    err_prox    = 1'b0;
                    estado_prox = OCIOSO;
                end
            end
            default: estado_prox = OCIOSO;
        endcase
    end

    // Result registers: held between results, pronto pulses on each new one
    always_ff @(posedge clock) begin
        if (reset) begin
            saida  <= '0;
            zero   <= 1'b1;
            pronto <= 1'b0;
            erro   <= 1'b0;
        end else begin
            pronto <= carrega;
            if (carrega) begin
                saida <= res_prox;
                zero  <= (res_prox == '0);
                erro  <= err_prox;
            end
        end
    end

endmodule
